fifo_lsram_ctrl: RTL

FIFO_LSRAM_CTRL -- requirements
Module: fifo_lsram_ctrl

---
 rtl/digitizer_fifo_pkg.sv | 13 +
 rtl/fifo_fwft_outbuf.sv | 59 +++++
 rtl/fifo_lsram_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/digitizer_fifo_pkg.sv
// Shared defaults and types for the digitizer LSRAM FIFO.
package digitizer_fifo_pkg;

  localparam int unsigned DefDataWidth = 40;
  localparam int unsigned DefAddrWidth = 10;

  // Word count for the default depth: 0 .. 2**DefAddrWidth inclusive.
  typedef logic [DefAddrWidth:0] count_t;

  // Occupancy of the 2-entry output buffer.
  typedef logic [1:0] buf_level_t;

endpackage

// File: rtl/fifo_fwft_outbuf.sv
// Two-entry first-word-fall-through buffer fed by the LSRAM read port.
// o_ready is one cycle ahead: high means a RAM read issued now still has a slot when it lands.
module fifo_fwft_outbuf
  import digitizer_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  buf_level_t            r_level;
  buf_level_t            w_level_d;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_pop;

  assign o_valid = (r_level != 2'd0);
  assign o_data  = r_head;
  assign w_pop   = o_valid & i_ready;

  always_comb begin
    w_level_d = r_level;
    if (i_valid & ~w_pop) begin
      w_level_d = r_level + 2'd1;
    end else if (~i_valid & w_pop) begin
      w_level_d = r_level - 2'd1;
    end
    o_ready = (w_level_d < 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_level <= w_level_d;
      if (w_pop) begin
        if (r_level == 2'd2) begin
          r_head <= r_tail;
          if (i_valid) r_tail <= i_data;
        end else if (i_valid) begin
          r_head <= i_data;
        end
      end else if (i_valid) begin
        if (r_level == 2'd0) r_head <= i_data;
        else                 r_tail <= i_data;
      end
    end
  end

endmodule

// File: rtl/fifo_lsram_ctrl.sv
// FWFT FIFO controller around an external two-port LSRAM with 1-cycle read latency.
// Define FIFO_LEVEL_FLAGS_EN to add registered ALMOST_FULL / ALMOST_EMPTY outputs.
module fifo_lsram_ctrl
  import digitizer_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned AFULL_TH   = 1008,
  parameter int unsigned AEMPTY_TH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  FULL,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  VALID,
  input  logic                  RE,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_W_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_W_DATA,
  output logic                  RAM_W_EN,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_EN,
`ifdef FIFO_LEVEL_FLAGS_EN
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
`endif
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA
);

  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CntFull = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  if ((AFULL_TH > (2**ADDR_WIDTH)) || (AEMPTY_TH > (2**ADDR_WIDTH))) begin : g_th_check
    $error("fifo_lsram_ctrl: level threshold exceeds FIFO depth");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic [ADDR_WIDTH:0]   w_count_d;
  logic [ADDR_WIDTH:0]   w_ram_cnt_d;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_inflight;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_issue;
  logic                  w_buf_ready;
  logic                  w_valid;

  // FULL is registered, so a pop in the full cycle never frees a slot for a same-cycle push.
  assign w_push     = WE & ~r_full & ~RST;
  assign w_pop      = w_valid & RE & ~RST;
  assign w_rd_issue = (r_ram_cnt != '0) & w_buf_ready & ~RST;

  always_comb begin
    w_count_d = r_count;
    if (w_push & ~w_pop) begin
      w_count_d = r_count + CntOne;
    end else if (~w_push & w_pop) begin
      w_count_d = r_count - CntOne;
    end
  end

  always_comb begin
    w_ram_cnt_d = r_ram_cnt;
    if (w_push & ~w_rd_issue) begin
      w_ram_cnt_d = r_ram_cnt + CntOne;
    end else if (~w_push & w_rd_issue) begin
      w_ram_cnt_d = r_ram_cnt - CntOne;
    end
  end

  // A read in flight at reset is dropped because r_inflight clears with everything else.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ram_cnt  <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_ram_cnt  <= w_ram_cnt_d;
      r_full     <= (w_count_d == CntFull);
      r_overflow <= r_overflow | (WE & r_full);
      r_inflight <= w_rd_issue;
      if (w_push)     r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  fifo_fwft_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_valid (r_inflight),
    .i_data  (RAM_R_DATA),
    .o_ready (w_buf_ready),
    .o_valid (w_valid),
    .o_data  (DOUT),
    .i_ready (RE)
  );

`ifdef FIFO_LEVEL_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AfTh = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeTh = AEMPTY_TH[ADDR_WIDTH:0];

  logic r_afull;
  logic r_aempty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_afull  <= (w_count_d >= AfTh);
      r_aempty <= (w_count_d <= AeTh);
    end
  end

  assign ALMOST_FULL  = r_afull;
  assign ALMOST_EMPTY = r_aempty;
`endif

  assign VALID      = w_valid;
  assign FULL       = r_full;
  assign COUNT      = r_count;
  assign OVERFLOW   = r_overflow;
  assign RAM_W_EN   = w_push;
  assign RAM_W_ADDR = r_wr_ptr;
  assign RAM_W_DATA = DIN;
  assign RAM_R_EN   = w_rd_issue;
  assign RAM_R_ADDR = r_rd_ptr;

endmodule
